// File: rtl/ewm_tile_sched_if.sv
// rtl/ewm_tile_sched_if.sv - handshake bundle between tile scheduler and its host/datapath
// Signals:
//   start, num_tiles      job launch from host
//   in_valid / in_ready   tile-pair acceptance handshake
//   mult_issue, issue_idx multiplier launch strobe and tile index
//   out_valid / out_ready result-tag handshake, out_idx = head tag
//   busy, done            job status
// Modports: master = host/datapath side, slave = scheduler side.
interface ewm_tile_sched_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] num_tiles;
  logic             in_valid;
  logic             in_ready;
  logic             mult_issue;
  logic [WIDTH-1:0] issue_idx;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_idx;
  logic             busy;
  logic             done;

  modport master (
    output start, num_tiles, in_valid, out_ready,
    input  in_ready, mult_issue, issue_idx, out_valid, out_idx, busy, done
  );

  modport slave (
    input  start, num_tiles, in_valid, out_ready,
    output in_ready, mult_issue, issue_idx, out_valid, out_idx, busy, done
  );
endinterface

// File: rtl/ewm_tile_sched.sv
// rtl/ewm_tile_sched.sv - credit-gated tile issue scheduler with result-tag FIFO
// Ports:
//   clk    sole clock, rising edge
//   rst_n  synchronous reset, active HIGH despite the name
//   bus    ewm_tile_sched_if.slave: start/num_tiles in, in_valid/in_ready accept,
//          mult_issue/issue_idx out, out_valid/out_ready/out_idx result tags, busy, done
// A tile is accepted only when a FIFO slot is guaranteed for its result, so the
// write at the end of the multiplier pipeline can never be refused.
module ewm_tile_sched #(
  parameter int WIDTH     = 16,
  parameter int LATENCY   = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ewm_tile_sched_if.slave bus
);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] num_q, issued_q, popped_q, issue_idx_q;
  logic             mult_issue_q;
  logic [PW:0]      infl_q, wptr_q, rptr_q;
  logic [LATENCY-1:0] vld_sr_q;
  logic [WIDTH-1:0] tag_sr_q [LATENCY];
  logic [WIDTH-1:0] fifo_q [OUT_DEPTH];

  logic [PW:0]      occ, credits, infl_d;
  logic [WIDTH-1:0] issued_d, popped_d;
  logic             fifo_empty, fifo_full, in_ready, accept, push, pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign occ        = wptr_q - rptr_q;
  assign credits    = DEPTH_C - infl_q - occ;
  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == DEPTH_C);

  assign in_ready = (state_q == RUN) && (issued_q != num_q) && (credits != '0);
  assign accept   = bus.in_valid && in_ready;
  assign push     = vld_sr_q[LATENCY-1];
  assign pop      = !fifo_empty && bus.out_ready;

  assign issued_d = issued_q + {{(WIDTH-1){1'b0}}, accept};
  assign popped_d = popped_q + {{(WIDTH-1){1'b0}}, pop};
  assign infl_d   = infl_q + {{PW{1'b0}}, accept} - {{PW{1'b0}}, push};

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= IDLE;
      num_q        <= '0;
      issued_q     <= '0;
      popped_q     <= '0;
      issue_idx_q  <= '0;
      mult_issue_q <= 1'b0;
      infl_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      vld_sr_q     <= '0;
      for (int i = 0; i < LATENCY; i++) tag_sr_q[i] <= '0;
    end else begin
      mult_issue_q <= accept;
      if (accept) issue_idx_q <= issued_q;

      // Stage 0 lines up with mult_issue; the last stage is the FIFO write.
      vld_sr_q[0] <= accept;
      tag_sr_q[0] <= issued_q;
      for (int i = 1; i < LATENCY; i++) begin
        vld_sr_q[i] <= vld_sr_q[i-1];
        tag_sr_q[i] <= tag_sr_q[i-1];
      end

      if (push) begin
        fifo_q[wptr_q[PW-1:0]] <= tag_sr_q[LATENCY-1];
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;

      infl_q   <= infl_d;
      issued_q <= issued_d;
      popped_q <= popped_d;

      case (state_q)
        IDLE: if (bus.start) begin
          num_q    <= bus.num_tiles;
          issued_q <= '0;
          popped_q <= '0;
          state_q  <= (bus.num_tiles == '0) ? DONE : RUN;
        end
        RUN:   if (accept && (issued_d == num_q)) state_q <= DRAIN;
        DRAIN: if ((infl_q == '0) && fifo_empty && (popped_q == num_q)) state_q <= DONE;
        DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.mult_issue = mult_issue_q;
  assign bus.issue_idx  = issue_idx_q;
  assign bus.out_valid  = !fifo_empty;
  assign bus.out_idx    = fifo_empty ? '0 : fifo_q[rptr_q[PW-1:0]];
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst_n)
    push |-> (!fifo_full || pop));
endmodule

// File: doc/ewm_tile_sched.md
EWM_TILE_SCHED -- requirements
Module: ewm_tile_sched

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 16, meaning the bit width of tile count and index fields.
REQ-002 The block SHALL provide parameter LATENCY, default 2, meaning the fixed multiplier cycles from issue to result valid.
REQ-003 The block SHALL provide parameter OUT_DEPTH, default 4, meaning the result-tag FIFO entries (power of two, >=2).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-high reset; sampled only on the clk rising edge.
REQ-006 start  input  1  pulse; begins a job when sampled in IDLE.
REQ-007 num_tiles  input  WIDTH  tiles in the job; sampled with start.
REQ-008 in_valid  input  1  an I/F tile pair is present at the datapath input.
REQ-009 in_ready  output  1  the controller accepts the tile this cycle.
REQ-010 mult_issue  output  1  registered pulse; the datapath launches the accepted tile into the multiplier.
REQ-011 issue_idx  output  WIDTH  index of the tile issued with mult_issue.
REQ-012 out_valid  output  1  the FIFO head result tag is available.
REQ-013 out_ready  input  1  the consumer takes the head result.
REQ-014 out_idx  output  WIDTH  tile index of the head result.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on job completion.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE->RUN on start with num_tiles!=0; start with num_tiles==0 SHALL go IDLE->DONE; start outside IDLE SHALL be ignored.
REQ-019 in_ready SHALL be 1 only in RUN, with issued<num_tiles and credits>0.
REQ-020 credits SHALL be OUT_DEPTH - (in-flight count + FIFO occupancy), combinational from the registered counts.
REQ-021 An accept is in_valid&&in_ready; each accept SHALL assert mult_issue the next cycle with issue_idx = accept ordinal (0-based), then increment the issue count.
REQ-022 A LATENCY-deep valid/tag shift register SHALL track in-flight tiles; the tag exiting it SHALL be written to the FIFO exactly LATENCY cycles after mult_issue.
REQ-023 The FIFO write SHALL never be refused; credit gating guarantees space; an overflow is a design error flagged by assertion.
REQ-024 out_valid = FIFO not empty; a pop on out_valid&&out_ready; out_idx SHALL remain stable while out_valid&&!out_ready.
REQ-025 A simultaneous push and pop SHALL leave occupancy unchanged, including at full and at empty (empty push+pop is not allowed: pop requires out_valid).
REQ-026 Credits SHALL reflect a pop in the same cycle's update only, so in_ready responds one cycle after a pop.
REQ-027 RUN->DRAIN when the final accept occurs (issue count reaches num_tiles).
REQ-028 DRAIN->DONE when in-flight count==0, FIFO empty, and pops total num_tiles.
REQ-029 DONE SHALL assert done for one cycle then return to IDLE.
REQ-030 Results SHALL leave in issue order; no tag is dropped or duplicated.
REQ-031 Counters SHALL be WIDTH bits and SHALL not wrap within a job (num_tiles <= 2^WIDTH-1).

Reset
REQ-032 While rst_n=1 at a clock edge: state=IDLE, all counters, shift register and FIFO pointers cleared; in_ready=0, mult_issue=0, issue_idx=0, out_valid=0, out_idx=0, busy=0, done=0.
REQ-033 Reset mid-job SHALL abandon in-flight and buffered tags with no done pulse; the next start SHALL run normally.

Verification
REQ-034 num_tiles=3, in_valid=1, out_ready=1 -> issue_idx 0,1,2 on consecutive cycles; out_idx 0,1,2 each LATENCY+1 cycles after accept; single done.
REQ-035 num_tiles=8, out_ready=0 -> exactly OUT_DEPTH (4) accepts, then in_ready=0; releasing out_ready -> remaining 4 complete in order, done once.
REQ-036 FIFO full with out_ready toggling 1/0 during in-flight writes -> no overflow, no lost/duplicate index, out_idx stable while stalled.
REQ-037 start with num_tiles=0 -> IDLE->DONE->IDLE, done pulse, no mult_issue, in_ready never 1.
REQ-038 rst_n=1 for one cycle after 2 issues of num_tiles=5 -> all outputs 0, no done; subsequent start num_tiles=2 -> indices 0,1, done.
REQ-039 start pulsed in RUN with different num_tiles -> ignored; original job count completes.
